// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b, one bit per clock, LSB first.
// A single full-subtractor cell is reused every cycle. Its borrow is held
// in a register between bits. The operands shift right past the cell. The
// difference shifts in from the MSB side, so after WIDTH bits it is aligned.
//
// Handshake rules, for both sides:
//   A transfer happens on a rising edge where valid and ready are both 1.
//   in_ready is 1 only in IDLE, and it is a direct decode of the state.
//   out_valid is registered. It stays 1, and d/borrow/zero stay stable,
//   until an edge where out_ready is 1.
//   Input and output never overlap. While a result waits for the
//   consumer, any operands offered on the input are ignored.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DONE.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             dbit;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  // Full-subtractor cell acting on the current LSBs and the stored borrow.
  always_comb begin
    x       = a_sh[0];
    y       = b_sh[0];
    dbit    = x ^ y ^ br;
    br_next = (~x & y) | (br & ~(x ^ y));
    d_next  = {dbit, d_sh[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  // Control FSM and datapath registers. A reset at any time aborts an
  // operation that is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      d_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      d         <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_next;
          br   <= br_next;
          cnt  <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            // Last bit: publish the completed result in the same edge.
            d         <= d_next;
            borrow    <= br_next;
            zero      <= (d_next == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor. A WIDTH=4 instance is driven from a
// queue-based scoreboard. A WIDTH=8 instance gets a few directed operations.
module tb_serial_subtractor;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT (WIDTH=4) ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] d;
  logic         borrow;
  logic         zero;
  logic [1:0]   state_dbg;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .borrow(borrow), .zero(zero), .state_dbg(state_dbg)
  );

  // ---------------- DUT (WIDTH=8) ----------------
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] d8;
  logic       borrow8;
  logic       zero8;
  logic [1:0] state_dbg8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .d(d8), .borrow(borrow8), .zero(zero8), .state_dbg(state_dbg8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];   // {borrow, zero, d}
  int           acc_q[$];   // cycle of the accepting edge
  logic         rand_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer subtraction.
  function automatic logic [W+1:0] model(input int av, input int bv);
    int diff;
    int dm;
    diff = av - bv;
    dm   = (diff + (1 << W)) % (1 << W);
    return {(diff < 0), (dm == 0), W'(dm)};
  endfunction

  // Monitor: checks the latency when a result appears, and checks the
  // value when the consumer takes it.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else check("latency", cyc - acc_q.pop_front(), W);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("result_without_op", 32'd1, 32'd0);
        else check("result", {borrow, zero, d}, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // Random back-pressure while rand_phase is set.
  always @(posedge clk) begin
    if (rand_phase) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  // Called #1 after an edge. Returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, output int acc);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      check("issue_timeout", 32'd1, 32'd0);
      acc = -1;
    end else begin
      a = av; b = bv; in_valid = 1'b1;
      exp_q.push_back(model(int'(av), int'(bv)));
      @(posedge clk); #1;
      acc = cyc;
      acc_q.push_back(cyc);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed, input logic eb, input logic ez);
    int t;
    t = 0;
    a8 = av; b8 = bv; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("w8_latency", t, 8);
    check("w8_result", {borrow8, zero8, d8}, {eb, ez, ed});
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int prev_acc;
    int t;
    logic [W+1:0] held;

    // Reset state.
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {borrow, zero, d}, '0);
    check("rst_state", state_dbg, 2'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 9 - 3; in_ready stays low through RUN.
    issue(4'd9, 4'd3, acc);
    for (int i = 0; i < W; i++) begin
      check("busy_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_d", d, 4'd6);

    // 2, 3: borrow case and equal operands.
    issue(4'd3, 4'd9, acc);
    issue(4'd5, 4'd5, acc);
    issue(4'd0, 4'd15, acc);

    // 4: consumer stalls; operands offered meanwhile are ignored.
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd12, 4'd4, acc);
    wait_out_valid();
    held = model(12, 4);
    for (int i = 0; i < 5; i++) begin
      a = 4'd1; b = 4'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold", {borrow, zero, d}, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("release_hold", {borrow, zero, d}, held);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_capture_after_stall", out_valid, 1'b0);
    end

    // 5: reset on the second RUN cycle aborts the operation.
    issue(4'd9, 4'd3, acc);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(4'd7, 4'd2, acc);
    wait_out_valid();
    check("after_abort_d", d, 4'd5);
    @(posedge clk); #1;

    // 6: exhaustive, back-to-back at full rate.
    prev_acc = -1;
    for (int i = 0; i < 256; i++) begin
      issue(W'(i >> 4), W'(i & 15), acc);
      if (prev_acc >= 0 && (i % 37) == 0) check("period", acc - prev_acc, W + 2);
      prev_acc = acc;
    end

    // Random operands under random back-pressure.
    rand_phase = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), acc);
    end
    rand_phase = 1'b0;
    #2;
    out_ready = 1'b1;

    // Drain.
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("drain_empty", exp_q.size(), 0);

    // WIDTH=8 instance.
    run8(8'd0, 8'd1, 8'd255, 1'b1, 1'b0);
    run8(8'd200, 8'd50, 8'd150, 1'b0, 1'b0);
    run8(8'd77, 8'd77, 8'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
